output_buffer: RTL

//   Transmit-side counterpart of the NPU input buffer. Captures 4-byte result

---
 rtl/output_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/output_buffer.sv
// Transmit-side output buffer: a small FIFO of 32-bit result words feeding a
// byte serializer on an 8-bit valid/ready port, byte order QA, QB, QC, QD.
module output_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLKEXT,
    input  logic              CLR_BUF_OUT,
    input  logic              EN_BUF_OUT,
    input  logic [7:0]        QA,
    input  logic [7:0]        QB,
    input  logic [7:0]        QC,
    input  logic [7:0]        QD,
    output logic              FULL_BUF_OUT,
    output logic              EMPTY_BUF_OUT,
    output logic              OVF_BUF_OUT,
    output logic [ADDR_W:0]   COUNT_BUF_OUT,
    output logic [7:0]        DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic              BUSY_BUF_OUT
);

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_SEND   = 1'b1;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [0:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       mem_q [DEPTH];
    logic              pop;
    logic              push;

    // A pop on the same edge frees a slot, so a full FIFO may still accept a write.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = 2'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (DOUT_READY) begin
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        shift_d = {shift_q[23:0], 8'h00};
                    end else if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        idx_d   = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        push  = EN_BUF_OUT && (!full_q || pop);
        ovf_d = ovf_q || (EN_BUF_OUT && !push);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge CLKEXT) begin
        if (CLR_BUF_OUT) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            shift_q  <= 32'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: stale words are unreachable once the pointers clear.
    always_ff @(posedge CLKEXT) begin
        if (!CLR_BUF_OUT && push) begin
            mem_q[wr_ptr_q] <= {QA, QB, QC, QD};
        end
    end

    assign DOUT          = shift_q[31:24];
    assign DOUT_VALID    = (state_q == ST_SEND);
    assign BUSY_BUF_OUT  = (state_q == ST_SEND);
    assign FULL_BUF_OUT  = full_q;
    assign EMPTY_BUF_OUT = empty_q;
    assign OVF_BUF_OUT   = ovf_q;
    assign COUNT_BUF_OUT = count_q;

endmodule
